regfile_wb_writer: RTL and testbench

- Write-side front end of the core's architectural register file.
- Accepts writeback results from the execute unit (EXU) and the load/store unit (LSU) over valid/ready channels.
- Arbitrates the two channels onto the single register-file write port (wen/waddr/wdata) and drops writes to x0.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards until the value is in the register file.

---
 rtl/regfile_wb_writer.sv | 226 ++++++++++++++++++++++
 tb/tb_regfile_wb_writer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_writer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// regfile_wb_writer
//
// Write-side front end of the architectural register file. Writeback results
// arrive from the execute unit (EXU) and the load/store unit (LSU) over
// independent valid/ready channels. Each channel has a one-entry buffer. A
// round-robin arbiter picks one full buffer per cycle and drives it onto the
// single registered write port. Writes to x0 consume a grant but never raise
// rf_wen. A per-register pending-write scoreboard lets decode detect RAW
// hazards until the value has actually reached the register file.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   alloc_valid/alloc_addr        decode allocates a destination (sets busy)
//   exu_valid/ready/addr/data     EXU writeback channel
//   lsu_valid/ready/addr/data     LSU writeback channel
//   rf_wen/rf_waddr/rf_wdata      registered register-file write port
//   raddr1/raddr2 -> busy1/busy2  combinational scoreboard queries
//   idle                          nothing buffered, in flight or pending
// -----------------------------------------------------------------------------
module regfile_wb_writer #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  alloc_valid,
    input  logic [ADDR_WIDTH-1:0] alloc_addr,

    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_addr,
    input  logic [DATA_WIDTH-1:0] exu_data,

    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_data,

    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,

    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  busy1,
    output logic                  busy2,

    output logic                  idle
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Encoding of the channel that received the most recent grant.
    localparam logic GNT_EXU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  exu_full_q, exu_full_d;
    logic [ADDR_WIDTH-1:0] exu_addr_q, exu_addr_d;
    logic [DATA_WIDTH-1:0] exu_data_q, exu_data_d;

    logic                  lsu_full_q, lsu_full_d;
    logic [ADDR_WIDTH-1:0] lsu_addr_q, lsu_addr_d;
    logic [DATA_WIDTH-1:0] lsu_data_q, lsu_data_d;

    logic                  last_grant_q, last_grant_d;

    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    logic [NUM_REGS-1:0]   busy_q, busy_d;

    // ------------------------------------------------------------------
    // Arbiter: purely a function of buffer occupancy and last_grant.
    // When both buffers hold a result, the channel that did not win last
    // time gets the port, so two streaming channels alternate.
    // ------------------------------------------------------------------
    logic exu_grant;
    logic lsu_grant;
    logic exu_xfer;
    logic lsu_xfer;

    always_comb begin
        exu_grant = exu_full_q & (!lsu_full_q | (last_grant_q == GNT_LSU));
        lsu_grant = lsu_full_q & (!exu_full_q | (last_grant_q == GNT_EXU));
    end

    // A buffer can accept when empty or when it drains this cycle, which
    // lets an uncontended channel sustain one result per clock. Ready is
    // forced low while reset is held so no source believes it handed off.
    always_comb begin
        exu_ready = !rst & (!exu_full_q | exu_grant);
        lsu_ready = !rst & (!lsu_full_q | lsu_grant);
        exu_xfer  = exu_valid & exu_ready;
        lsu_xfer  = lsu_valid & lsu_ready;
    end

    // ------------------------------------------------------------------
    // Channel buffers: drain on grant, load on transfer. A transfer on the
    // same edge as the grant simply reloads the entry.
    // ------------------------------------------------------------------
    always_comb begin
        exu_full_d = exu_full_q;
        exu_addr_d = exu_addr_q;
        exu_data_d = exu_data_q;
        if (exu_grant) begin
            exu_full_d = 1'b0;
        end
        if (exu_xfer) begin
            exu_full_d = 1'b1;
            exu_addr_d = exu_addr;
            exu_data_d = exu_data;
        end
    end

    always_comb begin
        lsu_full_d = lsu_full_q;
        lsu_addr_d = lsu_addr_q;
        lsu_data_d = lsu_data_q;
        if (lsu_grant) begin
            lsu_full_d = 1'b0;
        end
        if (lsu_xfer) begin
            lsu_full_d = 1'b1;
            lsu_addr_d = lsu_addr;
            lsu_data_d = lsu_data;
        end
    end

    // ------------------------------------------------------------------
    // Write port and round-robin pointer.
    // Address/data hold when idle so the port only toggles on real grants.
    // An x0 grant still updates address/data but leaves rf_wen low.
    // ------------------------------------------------------------------
    always_comb begin
        rf_wen_d     = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        last_grant_d = last_grant_q;
        if (exu_grant) begin
            rf_wen_d     = (exu_addr_q != '0);
            rf_waddr_d   = exu_addr_q;
            rf_wdata_d   = exu_data_q;
            last_grant_d = GNT_EXU;
        end else if (lsu_grant) begin
            rf_wen_d     = (lsu_addr_q != '0);
            rf_waddr_d   = lsu_addr_q;
            rf_wdata_d   = lsu_data_q;
            last_grant_d = GNT_LSU;
        end
    end

    // ------------------------------------------------------------------
    // Pending-write scoreboard.
    // A bit clears on the edge where rf_wen is high for its index, i.e.
    // the same edge the register file captures the data, so a reader that
    // sees busy low can read the register file directly. A same-edge
    // allocation of that index wins over the clear: the new producer's
    // result is still outstanding. x0 is never busy.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            always_comb begin
                busy_d[gi] = 1'b0;
            end
        end else begin : g_reg
            logic set_hit;
            logic clr_hit;
            always_comb begin
                set_hit    = alloc_valid & (alloc_addr == ADDR_WIDTH'(gi));
                clr_hit    = rf_wen_q & (rf_waddr_q == ADDR_WIDTH'(gi));
                busy_d[gi] = set_hit | (busy_q[gi] & !clr_hit);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exu_full_q   <= 1'b0;
            exu_addr_q   <= '0;
            exu_data_q   <= '0;
            lsu_full_q   <= 1'b0;
            lsu_addr_q   <= '0;
            lsu_data_q   <= '0;
            last_grant_q <= GNT_LSU;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            busy_q       <= '0;
        end else begin
            exu_full_q   <= exu_full_d;
            exu_addr_q   <= exu_addr_d;
            exu_data_q   <= exu_data_d;
            lsu_full_q   <= lsu_full_d;
            lsu_addr_q   <= lsu_addr_d;
            lsu_data_q   <= lsu_data_d;
            last_grant_q <= last_grant_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            busy_q       <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        rf_wen   = rf_wen_q;
        rf_waddr = rf_waddr_q;
        rf_wdata = rf_wdata_q;
        busy1    = busy_q[raddr1];
        busy2    = busy_q[raddr2];
        idle     = !exu_full_q & !lsu_full_q & !rf_wen_q & !(|busy_q);
    end

endmodule

// File: tb/tb_regfile_wb_writer.sv
`timescale 1ns/1ps
// Directed bench for regfile_wb_writer. Expected writes are queued per channel
// when a handshake completes; a monitor pops and matches them whenever the
// DUT raises rf_wen, so any lost, reordered, spurious or x0 write is flagged.
module tb_regfile_wb_writer;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          alloc_valid;
    logic [AW-1:0] alloc_addr;
    logic          exu_valid;
    logic          exu_ready;
    logic [AW-1:0] exu_addr;
    logic [DW-1:0] exu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_data;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic          busy1;
    logic          busy2;
    logic          idle;

    regfile_wb_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_valid(alloc_valid),
        .alloc_addr (alloc_addr),
        .exu_valid  (exu_valid),
        .exu_ready  (exu_ready),
        .exu_addr   (exu_addr),
        .exu_data   (exu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_addr   (lsu_addr),
        .lsu_data   (lsu_data),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .busy1      (busy1),
        .busy2      (busy2),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exu_q[$];
    wr_t lsu_q[$];
    int  exu_writes = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor: every rf_wen must match the head of one channel queue.
    always @(negedge clk) begin : mon
        logic hit;
        hit = 1'b0;
        if (rf_wen === 1'b1) begin
            if (exu_q.size() > 0 && exu_q[0].a === rf_waddr && exu_q[0].d === rf_wdata) begin
                void'(exu_q.pop_front());
                exu_writes++;
                hit = 1'b1;
            end else if (lsu_q.size() > 0 && lsu_q[0].a === rf_waddr && lsu_q[0].d === rf_wdata) begin
                void'(lsu_q.pop_front());
                hit = 1'b1;
            end
            $display("t=%0t write x%0d <= 0x%08h", $time, rf_waddr, rf_wdata);
            chk($sformatf("wr_match_x%0d", rf_waddr), {31'b0, hit}, 32'd1);
        end
    end

    task automatic exu_send(input logic [AW-1:0] aa, input logic [DW-1:0] dd, output int acc_cyc);
        exu_valid = 1'b1;
        exu_addr  = aa;
        exu_data  = dd;
        acc_cyc   = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exu_ready === 1'b1) begin
                exu_q.push_back(wr_t'{a: aa, d: dd});
                @(posedge clk);
                acc_cyc = cyc;
                #1;
                break;
            end
        end
        exu_valid = 1'b0;
        chk("exu_send_accepted", {31'b0, acc_cyc >= 0}, 32'd1);
    endtask

    task automatic lsu_send(input logic [AW-1:0] aa, input logic [DW-1:0] dd, output int acc_cyc);
        lsu_valid = 1'b1;
        lsu_addr  = aa;
        lsu_data  = dd;
        acc_cyc   = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lsu_ready === 1'b1) begin
                lsu_q.push_back(wr_t'{a: aa, d: dd});
                @(posedge clk);
                acc_cyc = cyc;
                #1;
                break;
            end
        end
        lsu_valid = 1'b0;
        chk("lsu_send_accepted", {31'b0, acc_cyc >= 0}, 32'd1);
    endtask

    int ec[4];
    int lc;
    int exu_base;

    initial begin
        rst         = 1'b1;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
        exu_valid   = 1'b0;
        exu_addr    = '0;
        exu_data    = '0;
        lsu_valid   = 1'b0;
        lsu_addr    = '0;
        lsu_data    = '0;
        raddr1      = '0;
        raddr2      = '0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_exu_ready", {31'b0, exu_ready}, 32'd0);
        chk("rst_lsu_ready", {31'b0, lsu_ready}, 32'd0);
        chk("rst_rf_wen",    {31'b0, rf_wen},    32'd0);
        chk("rst_busy1",     {31'b0, busy1},     32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_exu_ready", {31'b0, exu_ready}, 32'd1);
        chk("post_rst_lsu_ready", {31'b0, lsu_ready}, 32'd1);
        chk("post_rst_idle",      {31'b0, idle},      32'd1);
        chk("post_rst_waddr",     {27'b0, rf_waddr},  32'd0);
        chk("post_rst_wdata",     rf_wdata,           32'd0);

        // ---------------- single write to x5 ----------------
        @(posedge clk); #1;
        alloc_valid = 1'b1; alloc_addr = 5'd5; raddr1 = 5'd5; raddr2 = 5'd5;
        @(posedge clk); #1;
        alloc_valid = 1'b0;
        exu_valid = 1'b1; exu_addr = 5'd5; exu_data = 32'hDEADBEEF;
        exu_q.push_back(wr_t'{a: 5'd5, d: 32'hDEADBEEF});
        @(negedge clk);
        chk("sw_busy1_alloc", {31'b0, busy1},     32'd1);
        chk("sw_busy2_alloc", {31'b0, busy2},     32'd1);
        chk("sw_exu_ready",   {31'b0, exu_ready}, 32'd1);
        @(posedge clk); #1 exu_valid = 1'b0;          // transfer edge N
        @(negedge clk);
        chk("sw_wen_grant_cycle", {31'b0, rf_wen}, 32'd0);
        chk("sw_busy_grant_cycle", {31'b0, busy1}, 32'd1);
        @(negedge clk);
        chk("sw_wen",   {31'b0, rf_wen},   32'd1);
        chk("sw_waddr", {27'b0, rf_waddr}, 32'd5);
        chk("sw_wdata", rf_wdata,          32'hDEADBEEF);
        chk("sw_busy_during_write", {31'b0, busy1}, 32'd1);
        @(negedge clk);
        chk("sw_wen_after",   {31'b0, rf_wen}, 32'd0);
        chk("sw_busy_cleared", {31'b0, busy1}, 32'd0);
        chk("sw_wdata_hold",  rf_wdata,        32'hDEADBEEF);
        chk("sw_idle",        {31'b0, idle},   32'd1);

        // ---------------- async reset with EXU buffer full ----------------
        // Nothing is queued for x9: the monitor flags any write that leaks out.
        @(posedge clk); #1;
        alloc_valid = 1'b1; alloc_addr = 5'd9; raddr1 = 5'd9;
        exu_valid = 1'b1; exu_addr = 5'd9; exu_data = 32'h99;
        @(posedge clk); #1;
        alloc_valid = 1'b0; exu_valid = 1'b0;
        chk("rr_busy_before", {31'b0, busy1}, 32'd1);
        chk("rr_idle_before", {31'b0, idle},  32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rr_rf_wen",    {31'b0, rf_wen},    32'd0);
        chk("rr_busy1",     {31'b0, busy1},     32'd0);
        chk("rr_exu_ready", {31'b0, exu_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rr_exu_ready_after", {31'b0, exu_ready}, 32'd1);
        chk("rr_idle_after",      {31'b0, idle},      32'd1);
        repeat (2) @(negedge clk);
        chk("rr_no_write_idle", {31'b0, idle}, 32'd1);

        // ---------------- tie: both channels on the same edge ----------------
        @(posedge clk); #1;
        exu_valid = 1'b1; exu_addr = 5'd3; exu_data = 32'h11;
        lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'h22;
        exu_q.push_back(wr_t'{a: 5'd3, d: 32'h11});
        lsu_q.push_back(wr_t'{a: 5'd4, d: 32'h22});
        @(posedge clk); #1;
        exu_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        chk("tie_exu_ready", {31'b0, exu_ready}, 32'd1);
        chk("tie_lsu_ready", {31'b0, lsu_ready}, 32'd0);
        @(negedge clk);
        chk("tie_first_wen",   {31'b0, rf_wen},   32'd1);
        chk("tie_first_waddr", {27'b0, rf_waddr}, 32'd3);
        @(negedge clk);
        chk("tie_second_waddr", {27'b0, rf_waddr}, 32'd4);
        chk("tie_second_wdata", rf_wdata,          32'h22);
        @(negedge clk);
        chk("tie_done_wen", {31'b0, rf_wen}, 32'd0);

        // ---------------- x0 drop via LSU ----------------
        @(posedge clk); #1;
        raddr1 = 5'd0;
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("x0_ready_pre", {31'b0, lsu_ready}, 32'd1);
        @(posedge clk); #1 lsu_valid = 1'b0;
        @(negedge clk);
        chk("x0_ready_full", {31'b0, lsu_ready}, 32'd1);
        chk("x0_busy1",      {31'b0, busy1},     32'd0);
        @(negedge clk);
        chk("x0_no_wen", {31'b0, rf_wen}, 32'd0);
        @(negedge clk);
        chk("x0_no_wen_later", {31'b0, rf_wen}, 32'd0);
        chk("x0_idle",         {31'b0, idle},   32'd1);

        // ---------------- set/clear collision on x7 ----------------
        @(posedge clk); #1;
        alloc_valid = 1'b1; alloc_addr = 5'd7; raddr1 = 5'd7; raddr2 = 5'd7;
        @(posedge clk); #1;
        alloc_valid = 1'b0;
        exu_valid = 1'b1; exu_addr = 5'd7; exu_data = 32'h77;
        exu_q.push_back(wr_t'{a: 5'd7, d: 32'h77});
        @(posedge clk); #1 exu_valid = 1'b0;          // transfer edge
        @(posedge clk); #1;                           // rf_wen now high for x7
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        @(negedge clk);
        chk("col_wen",   {31'b0, rf_wen},   32'd1);
        chk("col_waddr", {27'b0, rf_waddr}, 32'd7);
        @(posedge clk); #1 alloc_valid = 1'b0;
        @(negedge clk);
        chk("col_busy1", {31'b0, busy1}, 32'd1);
        chk("col_busy2", {31'b0, busy2}, 32'd1);
        chk("col_idle",  {31'b0, idle},  32'd0);

        // ---------------- backpressure: both channels streaming ----------------
        exu_base = exu_writes;
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    exu_send(AW'(10 + k), 32'hE000_0000 + k, ec[k]);
            end
            begin
                for (int k = 0; k < 4; k++)
                    lsu_send(AW'(20 + k), 32'hA000_0000 + k, lc);
            end
            begin
                repeat (2) @(negedge clk);
                chk("bp_one_ready_a", int'(exu_ready) + int'(lsu_ready), 32'd1);
                @(negedge clk);
                chk("bp_one_ready_b", int'(exu_ready) + int'(lsu_ready), 32'd1);
            end
        join
        chk("bp_exu_gap_12", ec[2] - ec[1], 32'd2);
        chk("bp_exu_gap_23", ec[3] - ec[2], 32'd2);
        repeat (6) @(negedge clk);
        chk("bp_exu_writes", exu_writes - exu_base, 32'd4);
        chk("bp_exu_q_empty", exu_q.size(), 32'd0);
        chk("bp_lsu_q_empty", lsu_q.size(), 32'd0);
        chk("bp_wen_quiet",   {31'b0, rf_wen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
